// File: rtl/ctrl_pkg.sv
// Shared control-path types for the RV32 core: opcodes, control bundle, FSM states.
// CTRL_UPIMM_EN enables LUI/AUIPC decoding; the bundle layout is identical in both builds.
package ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_HALT   = 7'b1111111
    } opcode_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;
    localparam logic [1:0] ALUOP_UPIMM = 2'b11;

    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_JAL  = 2'b01;
    localparam logic [1:0] JT_JALR = 2'b10;

    localparam logic [1:0] UPIMM_NONE  = 2'b00;
    localparam logic [1:0] UPIMM_LUI   = 2'b01;
    localparam logic [1:0] UPIMM_AUIPC = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic [1:0] jump_type;
        logic       halt;
        logic [1:0] up_imm;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic ctrl_t ctrl_bubble();
        return '0;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
// CTRL_UPIMM_EN adds LUI/AUIPC; otherwise they decode as illegal. valid is left to the caller.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = ctrl_bubble();
        illegal_o = 1'b0;
        unique case (1'b1)
            (opcode_i == OP_R): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            (opcode_i == OP_IMM): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            (opcode_i == OP_LOAD): begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALUOP_ADD;
            end
            (opcode_i == OP_STORE): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            (opcode_i == OP_BRANCH): begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALUOP_BR;
            end
            (opcode_i == OP_JAL): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.jump_type = JT_JAL;
            end
            (opcode_i == OP_JALR): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.jump_type = JT_JALR;
            end
            (opcode_i == OP_HALT): begin
                ctrl_o.halt = 1'b1;
            end
`ifdef CTRL_UPIMM_EN
            (opcode_i == OP_LUI): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_UPIMM;
                ctrl_o.up_imm    = UPIMM_LUI;
            end
            (opcode_i == OP_AUIPC): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_UPIMM;
                ctrl_o.up_imm    = UPIMM_AUIPC;
            end
`endif
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined main control: decode in ID, NSTAGES bundle registers, stall/flush bubbles, HALT drain.
// CTRL_UPIMM_EN (see ctrl_decode) selects whether LUI/AUIPC are legal.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int NSTAGES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                opcode,
    input  logic                      id_valid,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      id_ready,
    output logic [NSTAGES*CTRL_W-1:0] ctrl_q,
    output logic                      illegal_op,
    output logic                      halted
);

    localparam int CW = $clog2(NSTAGES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(NSTAGES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    ctrl_t         stage_q [NSTAGES];
    ctrl_t         dec;
    ctrl_t         stage0_d;
    logic          dec_illegal;
    logic          accept;

    ctrl_decode u_decode (
        .opcode_i  (opcode),
        .ctrl_o    (dec),
        .illegal_o (dec_illegal)
    );

    assign id_ready = (state_q == ST_RUN) && !stall;
    assign accept   = id_valid && id_ready && !flush;

    // Illegal opcodes are reported but travel down the pipe as bubbles.
    always_comb begin
        stage0_d = ctrl_bubble();
        if (accept && !dec_illegal) begin
            stage0_d       = dec;
            stage0_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGES; k++) begin
                stage_q[k] <= ctrl_bubble();
            end
            illegal_op <= 1'b0;
        end else begin
            stage_q[0] <= stage0_d;
            for (int k = 1; k < NSTAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            illegal_op <= accept && dec_illegal;
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_pack
        assign ctrl_q[k*CTRL_W +: CTRL_W] = stage_q[k];
    end

    // HALTED is reached NSTAGES edges after the HALT accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            halted  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (accept && dec.halt) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_HALTED;
                        cnt_q   <= '0;
                        halted  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: queue of expected stage-0 bundles shifted per cycle.
module tb_pipe_controller;
    import ctrl_pkg::*;

    localparam int N = 3;
    localparam int W = 15;

    logic           clk;
    logic           rst_n;
    logic [6:0]     opcode;
    logic           id_valid;
    logic           stall;
    logic           flush;
    logic           id_ready;
    logic [N*W-1:0] ctrl_q;
    logic           illegal_op;
    logic           halted;

    pipe_controller #(.NSTAGES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .id_valid   (id_valid),
        .stall      (stall),
        .flush      (flush),
        .id_ready   (id_ready),
        .ctrl_q     (ctrl_q),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic m_run;
    logic m_halted;
    int   m_cnt;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IM  = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] HL  = 7'b1111111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] BAD = 7'b0000000;

    // Field order: v alusrc m2r regw mrd mwr aluop br jmp jt halt upimm
    function automatic logic [W-1:0] ref_bundle(input logic [6:0] op);
        case (op)
            R:   return 15'b1_0_0_1_0_0_10_0_0_00_0_00;
            IM:  return 15'b1_1_0_1_0_0_10_0_0_00_0_00;
            LD:  return 15'b1_1_1_1_1_0_00_0_0_00_0_00;
            ST:  return 15'b1_1_0_0_0_1_00_0_0_00_0_00;
            BR:  return 15'b1_0_0_0_0_0_01_1_0_00_0_00;
            JL:  return 15'b1_0_0_1_0_0_00_0_1_01_0_00;
            JR:  return 15'b1_1_0_1_0_0_00_0_1_10_0_00;
            HL:  return 15'b1_0_0_0_0_0_00_0_0_00_1_00;
`ifdef CTRL_UPIMM_EN
            LUI: return 15'b1_1_0_1_0_0_11_0_0_00_0_01;
            AUI: return 15'b1_1_0_1_0_0_11_0_0_00_0_10;
`endif
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b1;
        m_halted = 1'b0;
        m_cnt    = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back('0);
    endtask

    task automatic step(input logic [6:0] op, input logic v,
                        input logic st, input logic fl);
        logic [W-1:0]   b;
        logic           acc;
        logic [N*W-1:0] e;
        @(negedge clk);
        opcode   = op;
        id_valid = v;
        stall    = st;
        flush    = fl;
        #1;
        chk("id_ready", id_ready, m_run && !st);
        acc = v && m_run && !st && !fl;
        b = acc ? ref_bundle(op) : '0;
        exp_q.push_back(b);
        void'(exp_q.pop_front());
        if (m_run) begin
            if (acc && b[2]) begin
                m_run = 1'b0;
                m_cnt = N;
            end
        end else if (!m_halted) begin
            if (m_cnt == 1) m_halted = 1'b1;
            else m_cnt--;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) e[k*W +: W] = exp_q[N-1-k];
        chk("ctrl_q", ctrl_q, e);
        chk("illegal_op", illegal_op, acc && (ref_bundle(op) == '0));
        chk("halted", halted, m_halted);
    endtask

    task automatic do_reset(input logic st);
        @(negedge clk);
        #2;
        id_valid = 1'b0;
        flush    = 1'b0;
        stall    = st;
        rst_n    = 1'b0;
        #1;
        chk("rst_ctrl_q", ctrl_q, '0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_id_ready", id_ready, !st);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(BAD, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = '0;
        id_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        model_reset();
        do_reset(1'b0);

        step(R,  1, 0, 0);
        step(LD, 1, 0, 0);
        step(ST, 1, 0, 0);
        step(BR, 1, 0, 0);
        step(JL, 1, 0, 0);
        step(JR, 1, 0, 0);
        step(IM, 1, 0, 0);
        idle(N);

        step(LD, 1, 0, 0);
        step(BR, 1, 1, 0);
        step(BR, 1, 0, 0);
        idle(N);

        step(JL, 1, 1, 1);
        step(JL, 1, 0, 1);
        step(HL, 1, 0, 1);
        step(R,  1, 0, 0);
        idle(N);

        step(LUI, 1, 0, 0);
        step(AUI, 1, 0, 0);
        step(BAD, 1, 0, 0);
        step(R,   1, 0, 0);
        idle(N);

        step(HL, 1, 0, 0);
        step(JL, 1, 0, 0);
        step(JL, 1, 1, 0);
        step(JL, 1, 0, 0);
        step(JL, 1, 0, 0);
        step(R,  1, 0, 0);

        do_reset(1'b1);
        step(HL, 1, 0, 0);
        step(JL, 1, 0, 0);
        do_reset(1'b0);
        step(R, 1, 0, 0);
        idle(N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
